// File: rtl/hasti_sram_ctrl.sv
// hasti_sram_ctrl: AHB-lite (Hasti) slave front end for a 1K x 32 SRAM wrapper.
// The wrapper has a W0 write port and an R1 read port. The two ports share one
// address bus, so a write commit and a read issue can never happen in the same
// cycle. When a read address phase lands on a write data phase, the read is
// held for one wait state and issued from a register in the next cycle.
// Optional feature macro: HASTI_SRAM_ERR_EN. When it is defined, a transfer
// with nonzero upper address bits, or with HSIZE above word, gets a two-cycle
// ERROR response and never reaches the SRAM. When it is undefined, the upper
// address bits alias, HSIZE above word is treated as a word, and HRESP is 0.
module hasti_sram_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] W0A,
    output logic                  W0E,
    output logic [31:0]           W0I,
    output logic [31:0]           W0M,
    output logic [ADDR_WIDTH-1:0] R1A,
    output logic                  R1E,
    input  logic [31:0]           R1O
);

`ifdef HASTI_SRAM_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_WSTALL = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WDATA  = 2'd1,
        ST_WSTALL = 2'd2
    } state_t;
`endif

    // Byte-lane write mask. A misaligned half or word is widened to the
    // naturally aligned lanes that contain it. Sizes above word fall back to a
    // full-word mask.
    function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
        logic [31:0] m;
        case (size)
            3'd0: begin
                case (lane)
                    2'd0:    m = 32'h0000_00FF;
                    2'd1:    m = 32'h0000_FF00;
                    2'd2:    m = 32'h00FF_0000;
                    default: m = 32'hFF00_0000;
                endcase
            end
            3'd1:    m = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [2:0]              wr_size_q, wr_size_d;
    logic [1:0]              wr_lane_q, wr_lane_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;

    logic                    acc_s;
    logic                    bad_s;
    logic                    rd_s;
    logic                    wr_s;
    logic                    hreadyout_s;
    logic                    hresp_s;
    logic                    r1e_s;
    logic [ADDR_WIDTH-1:0]   r1a_s;
    logic                    w0e_s;
    logic [ADDR_WIDTH-1:0]   haddr_word_s;
    logic                    unused_s;

    // The reset term keeps R1E low while reset is held, even when a read is
    // being presented on the bus.
    assign acc_s        = RST_N & HSEL & HTRANS[1] & HREADY;
    assign haddr_word_s = HADDR[ADDR_WIDTH+1:2];

`ifdef HASTI_SRAM_ERR_EN
    assign bad_s    = acc_s & ((|HADDR[31:ADDR_WIDTH+2]) | (HSIZE > 3'd2));
    assign unused_s = HTRANS[0];
`else
    assign bad_s    = 1'b0;
    assign unused_s = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};
`endif

    assign rd_s = acc_s & ~bad_s & ~HWRITE;
    assign wr_s = acc_s & ~bad_s & HWRITE;

    // Next-state, port-enable and response logic for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        wr_size_d   = wr_size_q;
        wr_lane_d   = wr_lane_q;
        rd_addr_d   = rd_addr_q;
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
        r1e_s       = 1'b0;
        r1a_s       = haddr_word_s;
        w0e_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_s) begin
                    wr_addr_d = haddr_word_s;
                    wr_size_d = HSIZE;
                    wr_lane_d = HADDR[1:0];
                    state_d   = ST_WDATA;
                end else if (rd_s) begin
                    r1e_s   = 1'b1;
                    state_d = ST_IDLE;
`ifdef HASTI_SRAM_ERR_EN
                end else if (bad_s) begin
                    state_d = ST_ERR1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                // The write commits here no matter what follows it.
                w0e_s = 1'b1;
                if (rd_s) begin
                    // The write owns the shared address bus this cycle, so
                    // the read is held and issued next cycle.
                    hreadyout_s = 1'b0;
                    rd_addr_d   = haddr_word_s;
                    state_d     = ST_WSTALL;
                end else if (wr_s) begin
                    wr_addr_d = haddr_word_s;
                    wr_size_d = HSIZE;
                    wr_lane_d = HADDR[1:0];
                    state_d   = ST_WDATA;
`ifdef HASTI_SRAM_ERR_EN
                end else if (bad_s) begin
                    state_d = ST_ERR1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WSTALL: begin
                // The master is still presenting the held read. That repeat
                // is not treated as a new transfer.
                r1e_s   = 1'b1;
                r1a_s   = rd_addr_q;
                state_d = ST_IDLE;
            end
`ifdef HASTI_SRAM_ERR_EN
            ST_ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = 1'b1;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_s = 1'b1;
                if (wr_s) begin
                    wr_addr_d = haddr_word_s;
                    wr_size_d = HSIZE;
                    wr_lane_d = HADDR[1:0];
                    state_d   = ST_WDATA;
                end else if (rd_s) begin
                    r1e_s   = 1'b1;
                    state_d = ST_IDLE;
                end else if (bad_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pending-transfer registers. The asynchronous reset aborts any
    // in-flight write before its commit edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= {ADDR_WIDTH{1'b0}};
            wr_size_q <= 3'd0;
            wr_lane_q <= 2'd0;
            rd_addr_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_size_q <= wr_size_d;
            wr_lane_q <= wr_lane_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign HRDATA    = R1O;
    assign HREADYOUT = hreadyout_s;
    assign HRESP     = hresp_s;
    assign W0E       = w0e_s;
    assign W0A       = wr_addr_q;
    assign W0I       = HWDATA;
    assign W0M       = lane_mask(wr_size_q, wr_lane_q);
    assign R1E       = r1e_s;
    assign R1A       = r1a_s;

endmodule

// File: tb/tb_hasti_sram_ctrl.sv
// Testbench for hasti_sram_ctrl. It contains an SRAM array model and a
// bus-level reference model with a byte-masked memory image. Directed
// transfers are driven one cycle at a time. A compare process checks the DUT
// outputs at each falling edge, and a set of hand-computed literals pins the
// model itself.
module tb_hasti_sram_ctrl;
    localparam int AW = 10;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [AW-1:0] W0A;
    logic          W0E;
    logic [31:0]   W0I;
    logic [31:0]   W0M;
    logic [AW-1:0] R1A;
    logic          R1E;
    logic [31:0]   R1O = 32'd0;

    hasti_sram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .W0A(W0A), .W0E(W0E), .W0I(W0I), .W0M(W0M),
        .R1A(R1A), .R1E(R1E), .R1O(R1O)
    );

    always #5 CLK = ~CLK;

    // SRAM wrapper model: the read data appears one cycle after R1E.
    logic [31:0] sram [0:1023];
    always @(posedge CLK) begin
        if (R1E) R1O <= sram[R1A];
        if (W0E) sram[W0A] <= (sram[W0A] & ~W0M) | (W0I & W0M);
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic        exp_ready, exp_resp, exp_w0e, exp_r1e, exp_rdv;
    logic [31:0] exp_w0a, exp_w0m, exp_w0i, exp_r1a, exp_rdata;

    int          stall_cnt = 0;
    int          w0e_cnt   = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [31:0] last_w0m   = 32'd0;
    logic [31:0] last_w0i   = 32'd0;
    logic [31:0] last_w0a   = 32'd0;

    // Reference model state, kept at the bus-transaction level.
    logic [31:0] ref_mem [0:1023];
    bit          m_wr_pend = 1'b0;
    int          m_wr_word = 0;
    logic [31:0] m_wr_mask = 32'd0;
    bit          m_held = 1'b0;
    int          m_held_word = 0;
    bit          m_rd_pend = 1'b0;
    logic [31:0] m_rd_val = 32'd0;
    int          m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The mask covers the aligned group of nb bytes that contains the address.
    function automatic logic [31:0] exp_mask(input logic [31:0] addr, input logic [2:0] size);
        int nb;
        int lane0;
        logic [63:0] m;
        nb    = (size == 3'd0) ? 1 : ((size == 3'd1) ? 2 : 4);
        lane0 = (int'(addr[1:0]) / nb) * nb;
        m     = ((64'd1 << (8 * nb)) - 64'd1) << (8 * lane0);
        return m[31:0];
    endfunction

    // Compare process: checks the DUT outputs against the model on each falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("HREADYOUT", 32'(HREADYOUT), 32'(exp_ready));
            chk("HRESP", 32'(HRESP), 32'(exp_resp));
            chk("W0E", 32'(W0E), 32'(exp_w0e));
            if (exp_w0e) begin
                chk("W0A", 32'(W0A), exp_w0a);
                chk("W0M", W0M, exp_w0m);
                chk("W0I", W0I, exp_w0i);
            end
            chk("R1E", 32'(R1E), 32'(exp_r1e));
            if (exp_r1e) chk("R1A", 32'(R1A), exp_r1a);
            if (exp_rdv) begin
                chk("HRDATA", HRDATA, exp_rdata);
                last_rdata = HRDATA;
            end
            if (!HREADYOUT) stall_cnt++;
            if (W0E) begin
                w0e_cnt++;
                last_w0a = 32'(W0A);
                last_w0m = W0M;
                last_w0i = W0I;
            end
        end
    end

    // Drives one bus cycle and derives its expected outputs from the model.
    task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        bit acc, bad;
        int word;
        bit nwr, nheld, nrd;
        int nword, nheld_word, nerr;
        logic [31:0] nmask, nval;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
        HWDATA = wdata; HREADY = 1'b1;
        acc  = sel && trans[1];
        word = int'((addr >> 2) & 32'h3FF);
        bad  = 1'b0;
`ifdef HASTI_SRAM_ERR_EN
        bad = acc && (((addr >> (AW + 2)) != 32'd0) || (size > 3'd2));
`endif
        nwr = 1'b0; nheld = 1'b0; nrd = 1'b0; nerr = 0;
        nword = 0; nheld_word = 0; nmask = 32'd0; nval = 32'd0;
        exp_rdv = m_rd_pend; exp_rdata = m_rd_val;
        exp_w0e = m_wr_pend; exp_w0a = 32'(m_wr_word); exp_w0m = m_wr_mask; exp_w0i = wdata;
        if (m_wr_pend) ref_mem[m_wr_word] = (ref_mem[m_wr_word] & ~m_wr_mask) | (wdata & m_wr_mask);
        exp_ready = 1'b1; exp_resp = 1'b0; exp_r1e = 1'b0; exp_r1a = 32'd0;
        if (m_held) begin
            exp_r1e = 1'b1; exp_r1a = 32'(m_held_word);
            nrd = 1'b1; nval = ref_mem[m_held_word];
        end else if (m_err == 1) begin
            exp_ready = 1'b0; exp_resp = 1'b1; nerr = 2;
        end else begin
            exp_resp = (m_err == 2);
            if (acc && bad) begin
                nerr = 1;
            end else if (acc && !wr) begin
                if (m_wr_pend) begin
                    exp_ready = 1'b0; nheld = 1'b1; nheld_word = word;
                end else begin
                    exp_r1e = 1'b1; exp_r1a = 32'(word);
                    nrd = 1'b1; nval = ref_mem[word];
                end
            end else if (acc && wr) begin
                nwr = 1'b1; nword = word; nmask = exp_mask(addr, size);
            end
        end
        m_wr_pend = nwr; m_wr_word = nword; m_wr_mask = nmask;
        m_held = nheld; m_held_word = nheld_word;
        m_rd_pend = nrd; m_rd_val = nval; m_err = nerr;
        chk_en = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    int s_st, s_we;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        RST_N = 1'b0; HSEL = 1'b1; HTRANS = T_NS; HWRITE = 1'b0; HADDR = 32'h10;
        HSIZE = 3'd2; HREADY = 1'b1; HWDATA = 32'd0;
        #1;
        chk("rst HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("rst HRESP", 32'(HRESP), 32'd0);
        chk("rst W0E", 32'(W0E), 32'd0);
        chk("rst R1E", 32'(R1E), 32'd0);
        HSEL = 1'b0; HTRANS = T_IDLE;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Word write to 0x10, then a read after one idle cycle: no wait states.
        s_st = stall_cnt;
        step(1'b1, T_NS, 1'b1, 32'h10, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'hDEADBEEF);
        step(1'b1, T_NS, 1'b0, 32'h10, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        chk("lit word W0A", last_w0a, 32'd4);
        chk("lit word W0M", last_w0m, 32'hFFFFFFFF);
        chk("lit word rdata", last_rdata, 32'hDEADBEEF);
        chk("lit word stalls", 32'(stall_cnt - s_st), 32'd0);

        // Byte write to lane 3 of the same word.
        step(1'b1, T_NS, 1'b1, 32'h13, 3'd0, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'hAA123456);
        step(1'b1, T_NS, 1'b0, 32'h10, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        chk("lit byte W0M", last_w0m, 32'hFF000000);
        chk("lit byte W0I", last_w0i, 32'hAA123456);
        chk("lit byte rdata", last_rdata, 32'hAAADBEEF);
        chk("lit model word4", ref_mem[4], 32'hAAADBEEF);

        // Misaligned halfword at 0x17 covers the upper half of word 5.
        step(1'b1, T_NS, 1'b1, 32'h17, 3'd1, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'hCAFE1111);
        step(1'b1, T_SEQ, 1'b0, 32'h14, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        chk("lit half W0M", last_w0m, 32'hFFFF0000);
        chk("lit half rdata", last_rdata, 32'hCAFE0000);

        // A write followed at once by a read of the same address: one wait state.
        s_st = stall_cnt; s_we = w0e_cnt;
        step(1'b1, T_NS, 1'b1, 32'h20, 3'd2, 32'd0);
        step(1'b1, T_NS, 1'b0, 32'h20, 3'd2, 32'h0BADF00D);
        step(1'b1, T_NS, 1'b0, 32'h20, 3'd2, 32'h0BADF00D);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        chk("lit coll stalls", 32'(stall_cnt - s_st), 32'd1);
        chk("lit coll W0E", 32'(w0e_cnt - s_we), 32'd1);
        chk("lit coll rdata", last_rdata, 32'h0BADF00D);

        // Four back-to-back writes, then four back-to-back reads.
        s_st = stall_cnt; s_we = w0e_cnt;
        step(1'b1, T_NS, 1'b1, 32'h0, 3'd2, 32'd0);
        step(1'b1, T_NS, 1'b1, 32'h4, 3'd2, 32'h11111111);
        step(1'b1, T_NS, 1'b1, 32'h8, 3'd2, 32'h22222222);
        step(1'b1, T_NS, 1'b1, 32'hC, 3'd2, 32'h33333333);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h44444444);
        chk("lit b2b W0E", 32'(w0e_cnt - s_we), 32'd4);
        chk("lit b2b stalls", 32'(stall_cnt - s_st), 32'd0);
        chk("lit b2b last W0A", last_w0a, 32'd3);
        step(1'b1, T_NS, 1'b0, 32'h0, 3'd2, 32'd0);
        step(1'b1, T_NS, 1'b0, 32'h4, 3'd2, 32'd0);
        step(1'b1, T_NS, 1'b0, 32'h8, 3'd2, 32'd0);
        step(1'b1, T_NS, 1'b0, 32'hC, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        chk("lit b2b rdata", last_rdata, 32'h44444444);

        // BUSY and unselected transfers cause no access.
        s_we = w0e_cnt;
        step(1'b1, T_BUSY, 1'b1, 32'h0, 3'd2, 32'd0);
        step(1'b0, T_NS, 1'b1, 32'h4, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'hFFFFFFFF);
        chk("lit busy W0E", 32'(w0e_cnt - s_we), 32'd0);

        // Out-of-range read at 0x1000: aliases to word 0, or two-cycle ERROR.
        s_st = stall_cnt; last_rdata = 32'd0;
        step(1'b1, T_NS, 1'b0, 32'h1000, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
`ifdef HASTI_SRAM_ERR_EN
        chk("lit err stalls", 32'(stall_cnt - s_st), 32'd1);
`else
        chk("lit alias rdata", last_rdata, 32'h11111111);
`endif

        // A write with HSIZE=3: full-word mask, or ERROR with no commit.
        s_we = w0e_cnt;
        step(1'b1, T_NS, 1'b1, 32'h8, 3'd3, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'h55555555);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
`ifdef HASTI_SRAM_ERR_EN
        chk("lit size3 W0E", 32'(w0e_cnt - s_we), 32'd0);
`else
        chk("lit size3 W0E", 32'(w0e_cnt - s_we), 32'd1);
        chk("lit size3 W0M", last_w0m, 32'hFFFFFFFF);
`endif

        // Reset during a write data phase aborts it before the commit edge.
        step(1'b1, T_NS, 1'b1, 32'h40, 3'd2, 32'd0);
        chk_en = 1'b0;
        HSEL = 1'b1; HTRANS = T_NS; HWRITE = 1'b0; HADDR = 32'h44; HWDATA = 32'h12345678;
        #1;
        RST_N = 1'b0;
        #1;
        chk("mid rst W0E", 32'(W0E), 32'd0);
        chk("mid rst HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("mid rst HRESP", 32'(HRESP), 32'd0);
        chk("mid rst R1E", 32'(R1E), 32'd0);
        m_wr_pend = 1'b0; m_held = 1'b0; m_rd_pend = 1'b0; m_err = 0;
        HSEL = 1'b0; HTRANS = T_IDLE;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        last_rdata = 32'hFFFFFFFF;
        step(1'b1, T_NS, 1'b0, 32'h40, 3'd2, 32'd0);
        step(1'b0, T_IDLE, 1'b0, 32'h0, 3'd0, 32'd0);
        chk("lit rst no commit", last_rdata, 32'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
